// File: rtl/spc_sequencer.sv
// spc_sequencer: periodic trigger, response timeout and retry controller in front of spc_master.
// Latches good frames for the CPU side with a completion interrupt and a saturating error counter.
module spc_sequencer #(
  parameter  int MaxDatNibble_g = 6,
  parameter  int TimerWidth_g   = 16,
  parameter  int RetryWidth_g   = 2,
  localparam int FW             = MaxDatNibble_g*4+4
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Enable_i,
  input  logic [TimerWidth_g-1:0] Period_i,
  input  logic [TimerWidth_g-1:0] Timeout_i,
  input  logic [RetryWidth_g-1:0] MaxRetries_i,
  input  logic                    SPCReady_i,
  input  logic                    SPCNewData_i,
  input  logic                    SPCCrcOk_i,
  input  logic [FW-1:0]           SPCData_i,
  output logic                    SPCStart_o,
  output logic [FW-1:0]           Data_o,
  output logic                    DataValid_o,
  output logic [1:0]              LastErr_o,
  output logic [7:0]              ErrCount_o,
  input  logic                    ErrClear_i,
  output logic                    Irq_o,
  input  logic                    IrqAck_i,
  output logic                    Busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_PERIOD} state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_CRC = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

  state_t                  state_q, state_d;
  logic [TimerWidth_g-1:0] timer_q;
  logic [RetryWidth_g-1:0] retry_q;
  logic                    timer_zero;
  logic                    hit_ok, hit_crc, hit_tmo, fail, retry, done;
  logic [1:0]              fail_code;

  assign timer_zero = (timer_q == '0);
  assign Busy_o     = (state_q != S_IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Enable_i)   state_d = S_START;
      S_START:  if (SPCReady_i) state_d = S_WAIT;
      S_WAIT: begin
        if (done)       state_d = S_PERIOD;
        else if (retry) state_d = S_START;
      end
      S_PERIOD: if (timer_zero) state_d = Enable_i ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // A response in the cycle the timer expires still counts as a response.
  always_comb begin
    hit_ok  = 1'b0;
    hit_crc = 1'b0;
    hit_tmo = 1'b0;
    if (state_q == S_WAIT) begin
      if (SPCNewData_i) begin
        hit_ok  = SPCCrcOk_i;
        hit_crc = !SPCCrcOk_i;
      end else begin
        hit_tmo = timer_zero;
      end
    end
    fail      = hit_crc | hit_tmo;
    fail_code = hit_crc ? ERR_CRC : ERR_TMO;
    retry     = fail && (retry_q < MaxRetries_i);
    done      = hit_ok | (fail & !retry);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      timer_q     <= '0;
      retry_q     <= '0;
      SPCStart_o  <= 1'b0;
      Data_o      <= '0;
      DataValid_o <= 1'b0;
      LastErr_o   <= ERR_OK;
      ErrCount_o  <= '0;
      Irq_o       <= 1'b0;
    end else begin
      SPCStart_o <= (state_q == S_START) && SPCReady_i;
      case (state_q)
        S_START:  if (SPCReady_i) timer_q <= Timeout_i;
        S_WAIT: begin
          if (done)        timer_q <= Period_i;
          else if (!retry) timer_q <= timer_q - 1'b1;
        end
        S_PERIOD: if (!timer_zero) timer_q <= timer_q - 1'b1;
        default: ;
      endcase

      if (done)       retry_q <= '0;
      else if (retry) retry_q <= retry_q + 1'b1;

      if (hit_ok) begin
        Data_o      <= SPCData_i;
        DataValid_o <= 1'b1;
      end
      if (done) LastErr_o <= hit_ok ? ERR_OK : fail_code;

      if (ErrClear_i)                     ErrCount_o <= '0;
      else if (fail && ErrCount_o != '1)  ErrCount_o <= ErrCount_o + 1'b1;

      // A new completion beats a simultaneous acknowledge.
      if (done)          Irq_o <= 1'b1;
      else if (IrqAck_i) Irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spc_sequencer.sv
// Bench for spc_sequencer: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_spc_sequencer;
  localparam int FW = 28;
  localparam int TW = 16;
  localparam int RW = 2;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Enable_i = 1'b0;
  logic [TW-1:0] Period_i = '0, Timeout_i = '0;
  logic [RW-1:0] MaxRetries_i = '0;
  logic          SPCReady_i = 1'b0, SPCNewData_i = 1'b0, SPCCrcOk_i = 1'b0;
  logic [FW-1:0] SPCData_i = '0;
  logic          SPCStart_o, DataValid_o, Irq_o, Busy_o;
  logic [FW-1:0] Data_o;
  logic [1:0]    LastErr_o;
  logic [7:0]    ErrCount_o;
  logic          ErrClear_i = 1'b0;
  logic          ack_drv = 1'b0, resp_ack = 1'b0;
  logic          IrqAck_i;
  assign IrqAck_i = ack_drv | resp_ack;

  always #5 Clk = ~Clk;

  spc_sequencer #(.MaxDatNibble_g(6), .TimerWidth_g(TW), .RetryWidth_g(RW)) dut (
    .Clk(Clk), .Reset(Reset), .Enable_i(Enable_i), .Period_i(Period_i), .Timeout_i(Timeout_i),
    .MaxRetries_i(MaxRetries_i), .SPCReady_i(SPCReady_i), .SPCNewData_i(SPCNewData_i),
    .SPCCrcOk_i(SPCCrcOk_i), .SPCData_i(SPCData_i), .SPCStart_o(SPCStart_o), .Data_o(Data_o),
    .DataValid_o(DataValid_o), .LastErr_o(LastErr_o), .ErrCount_o(ErrCount_o),
    .ErrClear_i(ErrClear_i), .Irq_o(Irq_o), .IrqAck_i(IrqAck_i), .Busy_o(Busy_o));

  int n_chk = 0, n_err = 0;
  int n_start = 0, n_irq = 0;
  logic irq_prev = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- spc_master stand-in ----------------
  bit       resp_on = 1'b0, ack_w_resp = 1'b0, rand_mode = 1'b0;
  int       resp_delay = 0, rc = -1;
  logic [FW-1:0] resp_data = '0;
  bit       crc_q[$];

  always @(negedge Clk) begin
    SPCNewData_i = 1'b0;
    SPCCrcOk_i   = 1'b0;
    resp_ack     = 1'b0;
    if (Reset) rc = -1;
    else if (SPCStart_o) begin
      if (rand_mode) rc = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 12));
      else           rc = resp_on ? resp_delay : -1;
    end
    else if (rc > 0) rc--;
    else rc = -1;
    if (rc == 0) begin
      SPCNewData_i = 1'b1;
      if (rand_mode)            SPCCrcOk_i = ($urandom_range(0, 3) != 0);
      else if (crc_q.size() > 0) SPCCrcOk_i = crc_q.pop_front();
      else                      SPCCrcOk_i = 1'b1;
      SPCData_i = rand_mode ? FW'($urandom) : resp_data;
      resp_ack  = ack_w_resp;
    end
  end

  // ---------------- reference model ----------------
  logic          exp_start, exp_valid, exp_irq, exp_busy;
  logic [FW-1:0] exp_data;
  logic [1:0]    exp_lerr;
  logic [7:0]    exp_err;

  task automatic reset_expect();
    exp_start = 0; exp_valid = 0; exp_irq = 0; exp_busy = 0;
    exp_data = '0; exp_lerr = 2'b00; exp_err = 8'd0;
  endtask

  // One clock edge: per-cycle CPU-side effects, then the caller applies events.
  task automatic tick(output bit rst);
    @(posedge Clk);
    rst = Reset;
    if (!rst) begin
      exp_start = 1'b0;
      if (ErrClear_i) exp_err = 8'd0;
      if (IrqAck_i)   exp_irq = 1'b0;
    end
  endtask

  // Acquisition as a sequence of phases: idle, then attempts with retries, then a period.
  task automatic model_run();
    bit r;
    int t, p, k, tries, res;
    forever begin
      exp_busy = 1'b0;
      do begin tick(r); if (r) return; end while (!Enable_i);
      exp_busy = 1'b1;
      do begin
        tries = 0;
        forever begin
          do begin tick(r); if (r) return; end while (!SPCReady_i);
          exp_start = 1'b1;
          t = int'(Timeout_i);
          k = 0; res = 0;
          while (res == 0) begin
            tick(r); if (r) return;
            if (SPCNewData_i && SPCCrcOk_i) res = 1;
            else if (SPCNewData_i)          res = 2;
            else if (k == t)                res = 3;
            k++;
          end
          if (res == 1) begin
            exp_data = SPCData_i; exp_valid = 1'b1; exp_lerr = 2'b00; exp_irq = 1'b1;
            break;
          end
          if (!ErrClear_i && exp_err != 8'd255) exp_err = exp_err + 8'd1;
          if (tries < int'(MaxRetries_i)) tries++;
          else begin
            exp_lerr = (res == 2) ? 2'b01 : 2'b10;
            exp_irq  = 1'b1;
            break;
          end
        end
        p = int'(Period_i);
        repeat (p + 1) begin tick(r); if (r) return; end
      end while (Enable_i);
    end
  endtask

  initial forever begin
    reset_expect();
    wait (Reset === 1'b0);
    model_run();
  end

  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      check("cyc_start", SPCStart_o, exp_start);
      check("cyc_data",  Data_o,     exp_data);
      check("cyc_valid", DataValid_o, exp_valid);
      check("cyc_lerr",  LastErr_o,  exp_lerr);
      check("cyc_err",   ErrCount_o, exp_err);
      check("cyc_irq",   Irq_o,      exp_irq);
      check("cyc_busy",  Busy_o,     exp_busy);
    end
  end

  always @(posedge Clk) begin
    #1;
    if (SPCStart_o === 1'b1) n_start++;
    if (Irq_o === 1'b1 && !irq_prev) n_irq++;
    irq_prev = (Irq_o === 1'b1);
  end

  // ---------------- helpers ----------------
  function automatic bit cond(input int w);
    case (w)
      0:       return Irq_o === 1'b1;
      1:       return Busy_o === 1'b0;
      default: return SPCStart_o === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int w, input int lim, input string nm);
    int i = 0;
    while (!cond(w) && i < lim) begin @(negedge Clk); i++; end
    n_chk++;
    if (!cond(w)) begin
      n_err++;
      $display("FAIL %s: condition not reached, waited %0d cycles, limit %0d", nm, i, lim);
    end
  endtask

  task automatic pulse_ack();   ack_drv = 1;    @(negedge Clk); ack_drv = 0;    endtask
  task automatic pulse_clr();   ErrClear_i = 1; @(negedge Clk); ErrClear_i = 0; endtask
  task automatic pulse_en();    Enable_i = 1;   @(negedge Clk); Enable_i = 0;   endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    int s0, i0, k;
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_start", SPCStart_o, 0);
    check("rst_data",  Data_o, 0);
    check("rst_valid", DataValid_o, 0);
    check("rst_lerr",  LastErr_o, 0);
    check("rst_err",   ErrCount_o, 0);
    check("rst_irq",   Irq_o, 0);
    check("rst_busy",  Busy_o, 0);
    Reset = 1'b0;
    @(negedge Clk);

    // Nominal acquisition and the period to the next trigger
    Period_i = 10; Timeout_i = 50; MaxRetries_i = 0; SPCReady_i = 1;
    resp_on = 1; resp_delay = 20; resp_data = 28'h1234567;
    Enable_i = 1;
    wait_for(0, 200, "nom_irq");
    check("nom_data",   Data_o, 28'h1234567);
    check("nom_valid",  DataValid_o, 1);
    check("nom_lerr",   LastErr_o, 2'b00);
    check("nom_starts", n_start, 1);
    k = 0;
    do begin @(negedge Clk); k++; end while (SPCStart_o !== 1'b1 && k < 40);
    check("nom_gap", k, 12);
    Enable_i = 0;
    wait_for(1, 300, "nom_idle");
    pulse_ack();

    // Ready gating: START waits indefinitely for ready
    SPCReady_i = 0; resp_delay = 3; resp_data = 28'hABCDEF1;
    s0 = n_start;
    Enable_i = 1;
    repeat (30) @(negedge Clk);
    Enable_i = 0;
    check("gate_nostart", n_start - s0, 0);
    check("gate_busy", Busy_o, 1);
    SPCReady_i = 1;
    @(negedge Clk);
    check("gate_pulse", SPCStart_o, 1);
    wait_for(1, 100, "gate_idle");
    pulse_ack();

    // Timeout with two retries
    pulse_clr();
    resp_on = 0; MaxRetries_i = 2; Timeout_i = 5;
    s0 = n_start;
    pulse_en();
    wait_for(0, 200, "tmo_irq");
    check("tmo_starts", n_start - s0, 3);
    check("tmo_err",    ErrCount_o, 3);
    check("tmo_lerr",   LastErr_o, 2'b10);
    check("tmo_data",   Data_o, 28'hABCDEF1);
    wait_for(1, 100, "tmo_idle");
    pulse_ack();

    // CRC failure then success
    pulse_clr();
    crc_q.push_back(1'b0); crc_q.push_back(1'b1);
    resp_on = 1; resp_delay = 4; resp_data = 28'h0C0FFEE; Timeout_i = 20; MaxRetries_i = 1;
    i0 = n_irq;
    pulse_en();
    wait_for(1, 200, "crc_idle");
    check("crc_err",  ErrCount_o, 1);
    check("crc_lerr", LastErr_o, 2'b00);
    check("crc_data", Data_o, 28'h0C0FFEE);
    check("crc_irqs", n_irq - i0, 1);
    pulse_ack();

    // Saturation at 255, then clear coinciding with a failure
    resp_on = 0; Timeout_i = 0; Period_i = 0; MaxRetries_i = 0;
    Enable_i = 1;
    repeat (950) @(negedge Clk);
    check("sat_hold", ErrCount_o, 255);
    wait_for(2, 20, "sat_start");
    ErrClear_i = 1;
    @(negedge Clk);
    ErrClear_i = 0; Enable_i = 0;
    check("sat_clear", ErrCount_o, 0);
    wait_for(1, 50, "sat_idle");
    pulse_ack();

    // Response in the timer-expiry cycle, ack coinciding with completion
    Timeout_i = 6; Period_i = 3; resp_on = 1; resp_delay = 6; resp_data = 28'h5A5A5A5;
    ack_w_resp = 1;
    pulse_en();
    wait_for(1, 100, "sim_idle");
    check("sim_lerr", LastErr_o, 2'b00);
    check("sim_data", Data_o, 28'h5A5A5A5);
    check("sim_err",  ErrCount_o, 0);
    check("sim_irq",  Irq_o, 1);
    ack_w_resp = 0;
    pulse_ack();
    Timeout_i = 0; resp_delay = 0; resp_data = 28'h0000ABC;
    pulse_en();
    wait_for(1, 100, "t0_idle");
    check("t0_lerr", LastErr_o, 2'b00);
    check("t0_data", Data_o, 28'h0000ABC);
    pulse_ack();

    // Reset asserted in WAIT while the trigger pulse is high
    Timeout_i = 30; resp_on = 0; Enable_i = 1;
    wait_for(2, 20, "rst_wait_start");
    Reset = 1; Enable_i = 0;
    #1;
    check("rstw_start", SPCStart_o, 0);
    check("rstw_data",  Data_o, 0);
    check("rstw_valid", DataValid_o, 0);
    check("rstw_lerr",  LastErr_o, 0);
    check("rstw_err",   ErrCount_o, 0);
    check("rstw_irq",   Irq_o, 0);
    check("rstw_busy",  Busy_o, 0);
    s0 = n_start;
    repeat (5) @(negedge Clk);
    check("rstw_nostart", n_start - s0, 0);
    Reset = 0;
    @(negedge Clk);

    // Randomized soak against the model
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if ($urandom_range(0, 9) == 0) begin
        Period_i     = TW'($urandom_range(0, 8));
        Timeout_i    = TW'($urandom_range(0, 14));
        MaxRetries_i = RW'($urandom_range(0, 3));
      end
      Enable_i   = ($urandom_range(0, 9) != 0);
      SPCReady_i = ($urandom_range(0, 3) != 0);
      ack_drv    = ($urandom_range(0, 7) == 0);
      ErrClear_i = ($urandom_range(0, 40) == 0);
      if (c == 1500) Reset = 1;
      if (c == 1502) Reset = 0;
    end
    Enable_i = 0; ack_drv = 0; ErrClear_i = 0; SPCReady_i = 1;
    wait_for(1, 300, "rand_idle");
    rand_mode = 0;
    repeat (2) @(negedge Clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/spc_sequencer.md
# spc_sequencer

Autonomous acquisition controller for one `spc_master` instance. It issues SPC trigger pulses periodically, gated on the master's ready flag, and supervises each response with a timeout. On CRC error or timeout it retries up to a programmed count. Completed frames are latched for the CPU side, with an interrupt and a saturating error counter; the block sits between the peripheral register interface and `spc_master`.

## Interface
- `MaxDatNibble_g`, 6: matches `spc_master`; frame width FW = MaxDatNibble_g*4+4.
- `TimerWidth_g`, 16: width of period and timeout counters.
- `RetryWidth_g`, 2: width of retry limit and retry counter.

- `Clk` in 1: clock, rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Enable_i` in 1: run periodic acquisition.
- `Period_i` in TimerWidth_g: idle cycles between transactions.
- `Timeout_i` in TimerWidth_g: response wait limit, in cycles.
- `MaxRetries_i` in RetryWidth_g: extra attempts after a failure.
- `SPCReady_i` in 1: from `spc_master` SPCReady_o.
- `SPCNewData_i` in 1: from `spc_master` NewData_o.
- `SPCCrcOk_i` in 1: from `spc_master` CrcOk_o; valid with SPCNewData_i.
- `SPCData_i` in FW: from `spc_master` DataOut_o.
- `SPCStart_o` out 1: to `spc_master` Start_i; one-cycle pulse.
- `Data_o` out FW: last good frame.
- `DataValid_o` out 1: Data_o holds at least one good frame.
- `LastErr_o` out 2: status of last completion; 00 ok, 01 CRC, 10 timeout.
- `ErrCount_o` out 8: saturating failed-attempt count.
- `ErrClear_i` in 1: clears ErrCount_o.
- `Irq_o` out 1: completion interrupt, level.
- `IrqAck_i` in 1: clears Irq_o.
- `Busy_o` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, START, WAIT, PERIOD.
- IDLE: if Enable_i = 1, go to START.
- START: waits for SPCReady_i = 1. Then:
  - register SPCStart_o = 1 for the next cycle only;
  - load timer with Timeout_i;
  - go to WAIT.
  - While SPCReady_i = 0 the block stays in START indefinitely, with no timeout.
- WAIT: checks are evaluated in priority order.
  1. SPCNewData_i & SPCCrcOk_i (success): Data_o <= SPCData_i, DataValid_o <= 1, LastErr_o <= 00, retry counter <= 0, set Irq_o, go to PERIOD.
  2. SPCNewData_i & !SPCCrcOk_i: CRC failure, code 01.
  3. Timer == 0: timeout failure, code 10.
  4. Otherwise decrement the timer.
- Failure handling:
  - ErrCount_o increments, saturating at 255.
  - If retry counter < MaxRetries_i: increment retry counter and go to START. LastErr_o and Irq_o are unchanged.
  - Otherwise: LastErr_o <= code, retry counter <= 0, set Irq_o, go to PERIOD. Data_o is unchanged.
- PERIOD: on entry, timer <= Period_i. Decrement until timer == 0, then go to START if Enable_i = 1, else to IDLE.
- Enable_i low during START or WAIT does not abort: the current transaction, including its retries, completes. The exit to IDLE happens at the end of PERIOD.
- Enable_i low during PERIOD causes no early exit.
- ErrClear_i has priority over an increment in the same cycle; the result is 0.
- Irq_o: a set in the same cycle as IrqAck_i wins, so Irq_o stays 1.
- Configuration inputs are sampled only when the timer is loaded (START→WAIT, entry to PERIOD) and when the retry limit is compared.

## Timing
- Reset values:
  - state IDLE, timer 0, retry counter 0;
  - SPCStart_o 0, Data_o 0, DataValid_o 0, LastErr_o 00, ErrCount_o 0, Irq_o 0, Busy_o 0.
- All outputs are registered; Busy_o is decoded from the state register.
- IDLE→START takes 1 cycle after Enable_i is sampled high.
- START with SPCReady_i = 1: SPCStart_o is high in the first WAIT cycle.
- Timeout: with Timeout_i = T and no response, the failure is detected in the (T+1)-th WAIT cycle. T = 0 times out in the first WAIT cycle unless SPCNewData_i is high in that cycle.
- Period: Period_i = P gives P+1 cycles in PERIOD. Period_i = 0 gives a single PERIOD cycle.
- Data_o, LastErr_o, Irq_o and ErrCount_o update one cycle after the deciding WAIT cycle.
- Reset asserted mid-transaction returns all state to reset values immediately. SPCStart_o drops asynchronously.

## Test plan
- Nominal:
  - Stimulus: Period_i = 10, Timeout_i = 50, SPCReady_i = 1; the bench model returns frame 0x1234567 with CrcOk = 1 after 20 cycles.
  - Required: one SPCStart_o pulse; Data_o = 0x1234567, DataValid_o = 1, Irq_o = 1, LastErr_o = 00; next SPCStart_o exactly 12 cycles after the completion cycle.
- Ready gating:
  - Stimulus: hold SPCReady_i = 0 for 30 cycles.
  - Required: no SPCStart_o, Busy_o = 1; the pulse appears in the cycle after SPCReady_i rises.
- Timeout with retries:
  - Stimulus: MaxRetries_i = 2, Timeout_i = 5, no response.
  - Required: 3 SPCStart_o pulses, ErrCount_o = 3, LastErr_o = 10, Irq_o = 1, Data_o unchanged.
- CRC retry then success:
  - Stimulus: first response has CrcOk = 0, second has CrcOk = 1.
  - Required: ErrCount_o = 1, LastErr_o = 00, exactly one Irq_o assertion.
- Saturation and clear:
  - Stimulus: force 300 failures, then pulse ErrClear_i in the same cycle as a further failure.
  - Required: ErrCount_o holds at 255, then becomes 0.
- Simultaneous events and reset:
  - Stimulus: SPCNewData_i arrives in the cycle the timer reaches 0; IrqAck_i coincides with a completion; Reset is asserted in WAIT.
  - Required: the frame is accepted, not timed out; Irq_o stays 1; on Reset all outputs return to reset values with no further SPCStart_o.
